vault_read_arbiter: RTL and testbench

Shares the single 64-to-1 8-bit byte selector (`mux64to1_8bit`) among four requesters. Arbitrates among pending byte-read requests and drives the selector's 6-bit `sel`. Captures the selected byte (`treasure`) and returns it on a shared valid/ready response channel tagged with the requester id. Sits between the 512-bit vault storage and the blocks that need random byte access to it.

---
 rtl/vault_pkg.sv | 19 +
 rtl/vault_read_arbiter_if.sv | 27 ++
 rtl/mux64to1_8bit.sv | 13 +
 rtl/vault_rr_arbiter.sv | 33 +++
 rtl/vault_read_arbiter.sv | 112 +++++++++++
 tb/tb_vault_read_arbiter.sv | 222 ++++++++++++++++++++++
 6 files changed

// File: rtl/vault_pkg.sv
// rtl/vault_pkg.sv - shared sizes and FSM state type for the vault read arbiter
// Purpose: widths of the vault, byte index, requester id, and the arbiter FSM states.
// Ports: none (package).
package vault_pkg;

  localparam int VAULT_BYTES = 64;
  localparam int IDXW        = 6;
  localparam int NREQ        = 4;
  localparam int IDW         = 2;
  localparam int DATAW       = 8;
  localparam int VAULT_W     = VAULT_BYTES * DATAW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } vault_state_e;

endpackage

// File: rtl/vault_read_arbiter_if.sv
// rtl/vault_read_arbiter_if.sv - request/response handshake bundle for the vault read arbiter
// Purpose: groups the per-requester request lanes and the shared response channel.
// Signals: req_valid/req_idx (requesters -> arbiter), req_ready (one-hot grant),
//          resp_valid/resp_data/resp_id (arbiter -> consumer), resp_ready (consumer -> arbiter).
// Modports: master = requester/consumer side, slave = arbiter side.
interface vault_read_arbiter_if;
  import vault_pkg::*;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [NREQ-1:0]      req_ready;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [DATAW-1:0]     resp_data;
  logic [IDW-1:0]       resp_id;

  modport master (
    output req_valid, req_idx, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_idx, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );

endinterface

// File: rtl/mux64to1_8bit.sv
// rtl/mux64to1_8bit.sv - 64-to-1 byte selector over the 512-bit vault
// Purpose: returns byte sel of vault as treasure (purely combinational).
// Ports: vault (512-bit store, byte k = vault[8k+7:8k]), sel (6-bit byte index),
//        treasure (selected byte).
module mux64to1_8bit (
  input  logic [511:0] vault,
  input  logic [5:0]   sel,
  output logic [7:0]   treasure
);

  assign treasure = vault[{sel, 3'b000} +: 8];

endmodule

// File: rtl/vault_rr_arbiter.sv
// rtl/vault_rr_arbiter.sv - 4-way rotating-start grant generator
// Purpose: grants the first pending request found when searching upward from ptr (mod NREQ).
//          With ptr tied to 0 it is a plain fixed-priority arbiter (requester 0 highest).
// Ports: req (pending requests), ptr (search start), gnt (one-hot grant),
//        gnt_id (encoded winner), gnt_any (some request granted).
module vault_rr_arbiter
  import vault_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_any
);

  always_comb begin
    logic [IDW-1:0] cand;
    cand    = '0;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      // IDW-bit addition wraps naturally, giving the mod-NREQ search order.
      cand = ptr + IDW'(i);
      if (!gnt_any && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_id    = cand;
        gnt_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vault_read_arbiter.sv
// rtl/vault_read_arbiter.sv - shares one 64:1 byte selector among four byte-read requesters
// Purpose: arbitrates pending requests, drives the selector index, captures the selected
//          byte and returns it tagged with the requester id on a valid/ready channel.
// Ports: clk, rst (synchronous, active-high), vault (512-bit byte store),
//        bus (slave side of vault_read_arbiter_if), busy (FSM not idle).
// Configuration: VAULT_ARB_RR_EN defined selects round-robin arbitration with a
//                rotating pointer; undefined gives fixed priority (requester 0 highest).
module vault_read_arbiter
  import vault_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [VAULT_W-1:0]         vault,
  vault_read_arbiter_if.slave        bus,
  output logic                       busy
);

  vault_state_e    state;
  logic [IDXW-1:0] sel;
  logic [IDW-1:0]  id_q;
  logic            resp_valid;
  logic [DATAW-1:0] resp_data;
  logic [IDW-1:0]  resp_id;
  logic [DATAW-1:0] treasure;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic [NREQ-1:0] arb_req;
  logic [IDXW-1:0] win_idx;
  logic [IDW-1:0]  ptr;

`ifdef VAULT_ARB_RR_EN
  logic [IDW-1:0] ptr_q;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // Requests are only visible to the arbiter in IDLE and out of reset, so
  // req_ready can never pulse while a lookup is in flight or being discarded.
  assign arb_req = bus.req_valid & {NREQ{(state == IDLE) && !rst}};

  vault_rr_arbiter u_arb (
    .req     (arb_req),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) win_idx = bus.req_idx[i*IDXW +: IDXW];
    end
  end

  mux64to1_8bit u_mux (
    .vault    (vault),
    .sel      (sel),
    .treasure (treasure)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= '0;
      id_q       <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
`ifdef VAULT_ARB_RR_EN
      ptr_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            sel   <= win_idx;
            id_q  <= gnt_id;
            state <= LOOKUP;
`ifdef VAULT_ARB_RR_EN
            ptr_q <= gnt_id + IDW'(1);
`endif
          end
        end
        LOOKUP: begin
          // Byte is captured here, so later vault changes cannot reach the response.
          resp_data  <= treasure;
          resp_id    <= id_q;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_valid && bus.resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = gnt;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = resp_data;
  assign bus.resp_id    = resp_id;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_vault_read_arbiter.sv
// tb/tb_vault_read_arbiter.sv - directed self-checking bench for vault_read_arbiter
module tb_vault_read_arbiter;
  import vault_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [VAULT_W-1:0] vault;
  logic               busy;

  int checks = 0;
  int errors = 0;

  vault_read_arbiter_if bus ();

  vault_read_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .vault (vault),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_req(input int r, input logic [5:0] idx);
    bus.req_valid[r] = 1'b1;
    bus.req_idx[r*IDXW +: IDXW] = idx;
  endtask

  int t2_first, t2_second;
  int t3_exp[5];

  initial begin
`ifdef VAULT_ARB_RR_EN
    t2_first  = 3;
    t2_second = 1;
    t3_exp    = '{0, 1, 2, 3, 0};
`else
    t2_first  = 1;
    t2_second = 3;
    t3_exp    = '{0, 0, 0, 0, 0};
`endif
    bus.req_valid  = '0;
    bus.req_idx    = '0;
    bus.resp_ready = 1'b0;
    for (int k = 0; k < VAULT_BYTES; k++) vault[8*k +: 8] = 8'(k);

    // reset state
    do_reset();
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_resp_data", 32'(bus.resp_data), 0);
    check("rst_resp_id", 32'(bus.resp_id), 0);
    check("rst_busy", 32'(busy), 0);

    // single request: requester 2, idx 37
    set_req(2, 6'd37);
    bus.resp_ready = 1'b1;
    #1;
    check("t1_grant", 32'(bus.req_ready), 32'b0100);
    step();
    bus.req_valid = '0;
    #1;
    check("t1_lookup_busy", 32'(busy), 1);
    check("t1_lookup_rv", 32'(bus.resp_valid), 0);
    check("t1_lookup_rdy", 32'(bus.req_ready), 0);
    step();
    check("t1_rv", 32'(bus.resp_valid), 1);
    check("t1_data", 32'(bus.resp_data), 32'h25);
    check("t1_id", 32'(bus.resp_id), 2);
    step();
    check("t1_done_rv", 32'(bus.resp_valid), 0);
    check("t1_done_busy", 32'(busy), 0);

    // two simultaneous requesters: 1 (idx 5) and 3 (idx 63)
    set_req(1, 6'd5);
    set_req(3, 6'd63);
    #1;
    check("t2_grant1", 32'(bus.req_ready), 32'(1 << t2_first));
    step();
    bus.req_valid[t2_first] = 1'b0;
    #1;
    check("t2_lookup_rdy", 32'(bus.req_ready), 0);
    step();
    check("t2_resp1_rdy", 32'(bus.req_ready), 0);
    check("t2_resp1_id", 32'(bus.resp_id), 32'(t2_first));
    check("t2_resp1_data", 32'(bus.resp_data), (t2_first == 1) ? 32'h05 : 32'h3F);
    step();
    check("t2_grant2", 32'(bus.req_ready), 32'(1 << t2_second));
    step();
    bus.req_valid = '0;
    #1;
    step();
    check("t2_resp2_id", 32'(bus.resp_id), 32'(t2_second));
    check("t2_resp2_data", 32'(bus.resp_data), (t2_second == 1) ? 32'h05 : 32'h3F);
    step();

    // all four requesting continuously, fresh pointer
    do_reset();
    for (int r = 0; r < NREQ; r++) set_req(r, 6'(10 + r));
    bus.resp_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      check($sformatf("t3_grant%0d", g), 32'(bus.req_ready), 32'(1 << t3_exp[g]));
      step();
      step();
      check($sformatf("t3_id%0d", g), 32'(bus.resp_id), 32'(t3_exp[g]));
      check($sformatf("t3_data%0d", g), 32'(bus.resp_data), 32'(10 + t3_exp[g]));
      step();
    end
    bus.req_valid = '0;
    #1;

    // back-pressure: requester 1 idx 48, requester 2 waits
    step();
    step();
    step();
    check("t4_idle_busy", 32'(busy), 0);
    set_req(1, 6'd48);
    set_req(2, 6'd7);
    bus.resp_ready = 1'b0;
    #1;
    check("t4_grant", 32'(bus.req_ready), 32'b0010);
    step();
    bus.req_valid[1] = 1'b0;
    #1;
    step();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t4_hold_rv%0d", c), 32'(bus.resp_valid), 1);
      check($sformatf("t4_hold_data%0d", c), 32'(bus.resp_data), 32'h30);
      check($sformatf("t4_hold_id%0d", c), 32'(bus.resp_id), 1);
      check($sformatf("t4_hold_rdy%0d", c), 32'(bus.req_ready), 0);
      step();
    end
    bus.resp_ready = 1'b1;
    #1;
    step();
    check("t4_release_rv", 32'(bus.resp_valid), 0);
    check("t4_release_busy", 32'(busy), 0);
    check("t4_next_grant", 32'(bus.req_ready), 32'b0100);
    bus.req_valid = '0;
    #1;
    step();

    // reset during LOOKUP discards the access
    set_req(3, 6'd10);
    #1;
    check("t5_grant", 32'(bus.req_ready), 32'b1000);
    step();
    bus.req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t5_rst_rv", 32'(bus.resp_valid), 0);
    check("t5_rst_data", 32'(bus.resp_data), 0);
    check("t5_rst_id", 32'(bus.resp_id), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_rdy", 32'(bus.req_ready), 0);
    step();
    check("t5_no_resp", 32'(bus.resp_valid), 0);
    set_req(3, 6'd10);
    #1;
    check("t5_regrant", 32'(bus.req_ready), 32'b1000);
    step();
    bus.req_valid = '0;
    #1;
    step();
    check("t5_resp_rv", 32'(bus.resp_valid), 1);
    check("t5_resp_data", 32'(bus.resp_data), 32'h0A);
    check("t5_resp_id", 32'(bus.resp_id), 3);
    step();

    // vault change after capture does not alter the held byte
    set_req(2, 6'd20);
    bus.resp_ready = 1'b0;
    #1;
    step();
    bus.req_valid = '0;
    #1;
    step();
    check("t6_entry_data", 32'(bus.resp_data), 32'h14);
    step();
    vault[8*20 +: 8] = 8'hAA;
    #1;
    check("t6_held_data0", 32'(bus.resp_data), 32'h14);
    step();
    check("t6_held_data1", 32'(bus.resp_data), 32'h14);
    check("t6_held_rv", 32'(bus.resp_valid), 1);
    bus.resp_ready = 1'b1;
    #1;
    step();
    check("t6_done_rv", 32'(bus.resp_valid), 0);
    check("t6_done_busy", 32'(busy), 0);
    vault[8*20 +: 8] = 8'h14;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
